// File: rtl/timetag_cmd_pkg.sv
// rtl/timetag_cmd_pkg.sv - shared constants and FSM state type for the host command responder
//
// Purpose: opcode values, default status bytes and the responder state
//          encoding, imported by cmd_responder.
package timetag_cmd_pkg;

  localparam logic [7:0] OP_WRITE     = 8'h01;
  localparam logic [7:0] OP_READ      = 8'h02;
  localparam logic [7:0] DEF_WR_ACK   = 8'hA5;
  localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WR_EXEC,
    ST_RD_REQ,
    ST_RD_LATCH,
    ST_ERR,
    ST_REPLY
  } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous first-word-fall-through byte FIFO
//
// Purpose: buffers host command bytes until the parser consumes them.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_push, i_wdata push strobe and byte; ignored when full unless a pop
//                   happens in the same cycle
//   i_pop, o_rdata  pop strobe; o_rdata is the head byte (valid when !o_empty)
//   o_full, o_empty occupancy flags
module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic [7:0] i_wdata,
  input  logic       i_pop,
  output logic [7:0] o_rdata,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_rdata = r_mem[r_rptr];

  assign w_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/cmd_responder.sv
// rtl/cmd_responder.sv - host command parser, register access sequencer and reply shifter
//
// Purpose: parses WRITE (01 addr d0 d1 d2 d3) and READ (02 addr) frames from
//          the command byte stream, drives the register bus, and returns a
//          status byte or 4 read-data bytes (LSB first) over the reply handshake.
// Ports:
//   fx2_clk, reset            clock, synchronous active-high reset
//   cmd, cmd_wr               command byte and its one-cycle strobe
//   reply, reply_rdy          reply byte and its valid flag
//   reply_ack                 consumer took the current reply byte
//   reply_end                 marks the last byte of a reply
//   reg_addr, reg_wdata       register address / write data (held between accesses)
//   reg_wr, reg_rd            one-cycle register write / read strobes
//   reg_rdata                 register read data, valid one cycle after reg_rd
//   cmd_overflow              sticky: a command byte was dropped (FIFO full)
//   frame_timeout             one-cycle pulse when a partial frame is discarded
module cmd_responder
  import timetag_cmd_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 1024,
  parameter logic [7:0] WR_ACK     = DEF_WR_ACK,
  parameter logic [7:0] ERR_BYTE   = DEF_ERR_BYTE
) (
  input  logic        fx2_clk,
  input  logic        reset,
  input  logic [7:0]  cmd,
  input  logic        cmd_wr,
  output logic [7:0]  reply,
  output logic        reply_rdy,
  input  logic        reply_ack,
  output logic        reply_end,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [31:0] reg_rdata,
  output logic        cmd_overflow,
  output logic        frame_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  logic          r_is_write;
  logic [1:0]    r_byte_idx;
  logic [TW-1:0] r_tcnt;
  logic [23:0]   r_reply_sr;    // bytes still to send after the current one
  logic [2:0]    r_reply_left;  // bytes left including the current one
  logic [7:0]    r_reply;
  logic          r_reply_rdy;
  logic          r_reply_end;
  logic [7:0]    r_reg_addr;
  logic [31:0]   r_reg_wdata;
  logic          r_reg_wr;
  logic          r_reg_rd;
  logic          r_cmd_overflow;
  logic          r_frame_timeout;

  logic [7:0]    w_byte;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_drop;
  logic          w_in_frame;
  logic          w_timeout;

  assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_pop      = !w_empty &&
                      ((r_state == ST_IDLE) || w_in_frame);
  assign w_drop     = cmd_wr && w_full && !w_pop;
  // Fires on the TIMEOUT-th consecutive starved cycle inside a frame.
  assign w_timeout  = w_in_frame && w_empty && (r_tcnt == TW'(TIMEOUT - 1));

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (fx2_clk),
    .i_reset (reset),
    .i_push  (cmd_wr),
    .i_wdata (cmd),
    .i_pop   (w_pop),
    .o_rdata (w_byte),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_is_write      <= 1'b0;
      r_byte_idx      <= '0;
      r_tcnt          <= '0;
      r_reply_sr      <= '0;
      r_reply_left    <= '0;
      r_reply         <= '0;
      r_reply_rdy     <= 1'b0;
      r_reply_end     <= 1'b0;
      r_reg_addr      <= '0;
      r_reg_wdata     <= '0;
      r_reg_wr        <= 1'b0;
      r_reg_rd        <= 1'b0;
      r_cmd_overflow  <= 1'b0;
      r_frame_timeout <= 1'b0;
    end else begin
      r_reg_wr        <= 1'b0;
      r_reg_rd        <= 1'b0;
      r_frame_timeout <= 1'b0;

      if (w_drop) begin
        r_cmd_overflow <= 1'b1;
      end

      if (w_in_frame && w_empty) begin
        r_tcnt <= r_tcnt + TW'(1);
      end else begin
        r_tcnt <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            if (w_byte == OP_WRITE) begin
              r_is_write <= 1'b1;
              r_state    <= ST_ADDR;
            end else if (w_byte == OP_READ) begin
              r_is_write <= 1'b0;
              r_state    <= ST_ADDR;
            end else begin
              r_state <= ST_ERR;
            end
          end
        end

        ST_ADDR: begin
          if (w_timeout) begin
            r_frame_timeout <= 1'b1;
            r_state         <= ST_IDLE;
          end else if (!w_empty) begin
            r_reg_addr <= w_byte;
            if (r_is_write) begin
              r_byte_idx <= '0;
              r_state    <= ST_DATA;
            end else begin
              // Strobe is raised on entry so it is high during RD_REQ.
              r_reg_rd <= 1'b1;
              r_state  <= ST_RD_REQ;
            end
          end
        end

        ST_DATA: begin
          if (w_timeout) begin
            r_frame_timeout <= 1'b1;
            r_state         <= ST_IDLE;
          end else if (!w_empty) begin
            r_reg_wdata[{r_byte_idx, 3'b000} +: 8] <= w_byte;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_reg_wr <= 1'b1;
              r_state  <= ST_WR_EXEC;
            end
          end
        end

        ST_WR_EXEC: begin
          r_reply      <= WR_ACK;
          r_reply_left <= 3'd1;
          r_reply_end  <= 1'b1;
          r_reply_rdy  <= 1'b1;
          r_state      <= ST_REPLY;
        end

        ST_RD_REQ: begin
          r_state <= ST_RD_LATCH;
        end

        ST_RD_LATCH: begin
          r_reply      <= reg_rdata[7:0];
          r_reply_sr   <= reg_rdata[31:8];
          r_reply_left <= 3'd4;
          r_reply_end  <= 1'b0;
          r_reply_rdy  <= 1'b1;
          r_state      <= ST_REPLY;
        end

        ST_ERR: begin
          r_reply      <= ERR_BYTE;
          r_reply_left <= 3'd1;
          r_reply_end  <= 1'b1;
          r_reply_rdy  <= 1'b1;
          r_state      <= ST_REPLY;
        end

        ST_REPLY: begin
          if (reply_ack && r_reply_rdy) begin
            if (r_reply_left == 3'd1) begin
              r_reply_rdy <= 1'b0;
              r_reply_end <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_reply      <= r_reply_sr[7:0];
              r_reply_sr   <= {8'h00, r_reply_sr[23:8]};
              r_reply_left <= r_reply_left - 3'd1;
              r_reply_end  <= (r_reply_left == 3'd2);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign reply         = r_reply;
  assign reply_rdy     = r_reply_rdy;
  assign reply_end     = r_reply_end;
  assign reg_addr      = r_reg_addr;
  assign reg_wdata     = r_reg_wdata;
  assign reg_wr        = r_reg_wr;
  assign reg_rd        = r_reg_rd;
  assign cmd_overflow  = r_cmd_overflow;
  assign frame_timeout = r_frame_timeout;

endmodule
